// File: rtl/al_accel_pu_ctrl.sv
// Layer-pass sequencer for the 3x3x3 PU array: weight load, then a serpentine window scan.
// Optional perf counters are compiled in with `define AL_ACCEL_PU_CTRL_PERF_EN.
module al_accel_pu_ctrl #(
    parameter int CNT_W         = 8,
    parameter int CYC_W         = 5,
    parameter int DEF_PU_CYCLES = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_out_w,
    input  logic [CNT_W-1:0] cfg_out_h,
    input  logic [CYC_W-1:0] cfg_pu_cycles,
    input  logic             cfg_is_conv,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             res_ready,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_row,
    output logic [CNT_W-1:0] res_col,
    output logic [8:0]       wreg_enb,
    output logic [2:0]       ireg_enb,
    output logic [2:0]       pu_enb,
    output logic [1:0]       pu_arr_conv_dir,
    output logic             pu_arr_is_conv_layer,
    output logic             busy,
    output logic             done
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_busy_cyc,
    output logic [31:0]      perf_stall_cyc
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_I, S_COMPUTE, S_RESULT, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DIR_NON = 2'b00, DIR_LEFT = 2'b01, DIR_RIGHT = 2'b10, DIR_DOWN = 2'b11
    } dir_t;

    state_t           state, state_nxt;
    dir_t             dir, dir_adv;
    logic [CNT_W-1:0] w_lat, h_lat, row, col, row_adv, col_adv;
    logic [CYC_W-1:0] p_lat, cyc;
    logic             conv_lat, row_end, last_win, cyc_last;

    assign busy                 = (state != S_IDLE);
    assign res_row              = row;
    assign res_col              = col;
    assign pu_arr_conv_dir      = dir;
    assign pu_arr_is_conv_layer = conv_lat;
    assign cyc_last             = (cyc == p_lat - CYC_W'(1));

    // Serpentine: even rows run left-to-right, odd rows right-to-left.
    always_comb begin
        row_end  = row[0] ? (col == '0) : (col == w_lat - CNT_W'(1));
        last_win = row_end && (row == h_lat - CNT_W'(1));
        row_adv  = row;
        col_adv  = col;
        dir_adv  = DIR_NON;
        if (row_end) begin
            row_adv = row + CNT_W'(1);
            dir_adv = DIR_DOWN;
        end else if (row[0]) begin
            col_adv = col - CNT_W'(1);
            dir_adv = DIR_RIGHT;
        end else begin
            col_adv = col + CNT_W'(1);
            dir_adv = DIR_LEFT;
        end
        if (!conv_lat) dir_adv = DIR_NON;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        wreg_enb  = '0;
        ireg_enb  = '0;
        pu_enb    = '0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start)
                    state_nxt = (cfg_out_w == '0 || cfg_out_h == '0) ? S_DONE : S_LOAD_W;
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    wreg_enb  = '1;
                    state_nxt = S_LOAD_I;
                end
            end
            S_LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ireg_enb  = '1;
                    state_nxt = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                pu_enb = '1;
                if (cyc_last) state_nxt = S_RESULT;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = last_win ? S_DONE : S_LOAD_I;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_lat    <= '0;
            h_lat    <= '0;
            p_lat    <= '0;
            conv_lat <= 1'b0;
            row      <= '0;
            col      <= '0;
            dir      <= DIR_NON;
            cyc      <= '0;
        end else if (abort) begin
            row <= '0;
            col <= '0;
            dir <= DIR_NON;
            cyc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w_lat    <= cfg_out_w;
                        h_lat    <= cfg_out_h;
                        p_lat    <= (cfg_pu_cycles == '0) ? CYC_W'(DEF_PU_CYCLES) : cfg_pu_cycles;
                        conv_lat <= cfg_is_conv;
                        row      <= '0;
                        col      <= '0;
                        dir      <= DIR_NON;
                    end
                end
                S_LOAD_W: begin
                    if (w_valid) begin
                        row <= '0;
                        col <= '0;
                        dir <= DIR_NON;
                    end
                end
                S_LOAD_I:  if (in_valid) cyc <= '0;
                S_COMPUTE: cyc <= cyc + CYC_W'(1);
                S_RESULT: begin
                    if (res_ready && !last_win) begin
                        row <= row_adv;
                        col <= col_adv;
                        dir <= dir_adv;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef AL_ACCEL_PU_CTRL_PERF_EN
    logic stall_now;
    assign stall_now = (state == S_LOAD_W && !w_valid) ||
                       (state == S_LOAD_I && !in_valid) ||
                       (state == S_RESULT && !res_ready);

    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && start && !abort)) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && perf_busy_cyc != '1)       perf_busy_cyc  <= perf_busy_cyc + 32'd1;
            if (stall_now && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_al_accel_pu_ctrl.sv
// Scoreboard bench for al_accel_pu_ctrl: expected windows queued from a scan model, popped per result.
module tb_al_accel_pu_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] cfg_out_w, cfg_out_h;
    logic [4:0] cfg_pu_cycles;
    logic       cfg_is_conv;
    logic       w_valid, w_ready, in_valid, in_ready, res_ready, res_valid;
    logic [7:0] res_row, res_col;
    logic [8:0] wreg_enb;
    logic [2:0] ireg_enb, pu_enb;
    logic [1:0] pu_arr_conv_dir;
    logic       pu_arr_is_conv_layer, busy, done;
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    al_accel_pu_ctrl #(.CNT_W(8), .CYC_W(5), .DEF_PU_CYCLES(9)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_pu_cycles(cfg_pu_cycles),
        .cfg_is_conv(cfg_is_conv), .w_valid(w_valid), .w_ready(w_ready),
        .in_valid(in_valid), .in_ready(in_ready), .res_ready(res_ready), .res_valid(res_valid),
        .res_row(res_row), .res_col(res_col), .wreg_enb(wreg_enb), .ireg_enb(ireg_enb),
        .pu_enb(pu_enb), .pu_arr_conv_dir(pu_arr_conv_dir),
        .pu_arr_is_conv_layer(pu_arr_is_conv_layer), .busy(busy), .done(done)
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
        , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int exp_row[$], exp_col[$], exp_dir[$];
    int obs_row[$], obs_col[$], obs_dir[$], obs_pu[$];
    int stall_dir[$], stall_ireg[$], stall_row[$], stall_col[$], stall_pu[$];
    int done_cyc, wreg_cnt, any_en, ab_busy, ab_en, perf_b, perf_s;
    bit timed_out;

    // Reference serpentine scan; dir is the direction shown during that window's input load.
    task automatic model_scan(input int w, input int h, input int conv);
        int r = 0, c = 0, d = 0;
        bit re;
        for (int i = 0; i < w * h; i++) begin
            exp_row.push_back(r);
            exp_col.push_back(c);
            exp_dir.push_back(d);
            re = (r % 2 == 1) ? (c == 0) : (c == w - 1);
            if (re)              begin r++; d = 3; end
            else if (r % 2 == 1) begin c--; d = 2; end
            else                 begin c++; d = 1; end
            if (conv == 0) d = 0;
        end
    endtask

    task automatic run_pass(input int w, input int h, input int p, input int conv,
                            input int iv_win, input int iv_len,
                            input int rr_win, input int rr_len, input int ab_win);
        int cyc = 0, win = 0, ivc = 0, rrc = 0, pucnt = 0, post = 0;
        bit aborted = 0;
        obs_row.delete(); obs_col.delete(); obs_dir.delete(); obs_pu.delete();
        stall_dir.delete(); stall_ireg.delete(); stall_row.delete(); stall_col.delete(); stall_pu.delete();
        done_cyc = -1; wreg_cnt = 0; any_en = 0; timed_out = 0; ab_busy = -1; ab_en = -1;
        perf_b = -1; perf_s = -1;
        @(negedge clk);
        cfg_out_w = 8'(w); cfg_out_h = 8'(h); cfg_pu_cycles = 5'(p); cfg_is_conv = 1'(conv);
        w_valid = 1; in_valid = 1; res_ready = 1; abort = 0; start = 1;
        while (1) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = 0;
            if (cyc == 1) begin
                cfg_out_w = 8'($urandom); cfg_out_h = 8'($urandom);
                cfg_pu_cycles = 5'($urandom); cfg_is_conv = 1'($urandom);
            end
            if (cyc == 30 && !aborted) start = 1;
            in_valid = 1;
            if (in_ready && win == iv_win && ivc < iv_len) begin in_valid = 0; ivc++; end
            res_ready = 1;
            if (res_valid && win == rr_win && rrc < rr_len) begin res_ready = 0; rrc++; end
            abort = 0;
            if (ab_win >= 0 && !aborted && win == ab_win && pu_enb == 3'b111) begin
                abort = 1; aborted = 1;
            end
            #1;
            if (wreg_enb == 9'h1FF) wreg_cnt++;
            if (wreg_enb != 0 || ireg_enb != 0 || pu_enb != 0) any_en++;
            if (in_ready && !in_valid) begin
                stall_dir.push_back(int'(pu_arr_conv_dir)); stall_ireg.push_back(int'(ireg_enb));
            end
            if (in_ready && in_valid) obs_dir.push_back(int'(pu_arr_conv_dir));
            if (pu_enb == 3'b111) pucnt++;
            if (res_valid && !res_ready) begin
                stall_row.push_back(int'(res_row)); stall_col.push_back(int'(res_col));
                stall_pu.push_back(int'(pu_enb));
            end
            if (res_valid && res_ready) begin
                obs_row.push_back(int'(res_row)); obs_col.push_back(int'(res_col));
                obs_pu.push_back(pucnt); pucnt = 0; win++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            if (aborted) begin
                if (post == 1) begin
                    ab_busy = int'(busy);
                    ab_en = int'(wreg_enb != 0 || ireg_enb != 0 || pu_enb != 0 ||
                                 w_ready || in_ready || res_valid);
                end
                post++;
            end
            if (done_cyc >= 0 || post >= 6) break;
            if (cyc >= 3000) begin timed_out = 1; break; end
        end
        abort = 0; in_valid = 1; res_ready = 1;
        if (done_cyc >= 0) begin
            @(posedge clk);
            #1;
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
            perf_b = int'(perf_busy_cyc);
            perf_s = int'(perf_stall_cyc);
`endif
        end
    endtask

    task automatic test_reset;
        reset = 1; start = 0; abort = 0; w_valid = 0; in_valid = 0; res_ready = 0;
        cfg_out_w = 0; cfg_out_h = 0; cfg_pu_cycles = 0; cfg_is_conv = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if ({busy, done, w_ready, in_ready, res_valid, wreg_enb, ireg_enb, pu_enb,
             pu_arr_conv_dir, res_row, res_col, pu_arr_is_conv_layer} !== '0) begin
            errors++; $display("FAIL reset_outputs: got busy=%b pu=%b dir=%b row=%0d col=%0d, required all 0",
                               busy, pu_enb, pu_arr_conv_dir, res_row, res_col);
        end
        @(negedge clk);
        cfg_out_w = 3; cfg_out_h = 3; cfg_pu_cycles = 9; cfg_is_conv = 1;
        w_valid = 1; in_valid = 1; res_ready = 1; start = 1;
        @(negedge clk);
        start = 0;
        repeat (40) @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, w_ready, in_ready, res_valid, wreg_enb, ireg_enb, pu_enb,
             pu_arr_conv_dir, res_row, res_col, pu_arr_is_conv_layer} !== '0) begin
            errors++; $display("FAIL reset_midpass: got busy=%b pu=%b dir=%b row=%0d col=%0d, required all 0",
                               busy, pu_enb, pu_arr_conv_dir, res_row, res_col);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_conv_3x3(input string tag);
        int e, o;
        model_scan(3, 3, 1);
        run_pass(3, 3, 9, 1, -1, 0, -1, 0, -1);
        checks++;
        if (timed_out) begin errors++; $display("FAIL %s_timeout: no done within budget", tag); end
        while (exp_row.size() > 0) begin
            e = exp_dir.pop_front(); o = obs_dir.size() ? obs_dir.pop_front() : -1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s_dir: got %0d required %0d", tag, o, e); end
            e = exp_col.pop_front(); o = obs_col.size() ? obs_col.pop_front() : -1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s_col: got %0d required %0d", tag, o, e); end
            e = exp_row.pop_front(); o = obs_row.size() ? obs_row.pop_front() : -1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL %s_row: got %0d required %0d", tag, o, e); end
            o = obs_pu.size() ? obs_pu.pop_front() : -1;
            checks++;
            if (o !== 9) begin errors++; $display("FAIL %s_pu_cycles: got %0d required 9", tag, o); end
        end
        checks++;
        if (obs_row.size() != 0) begin
            errors++; $display("FAIL %s_extra_results: got %0d extra required 0", tag, obs_row.size());
        end
        checks++;
        if (done_cyc !== 101) begin errors++; $display("FAIL %s_done_cycle: got %0d required 101", tag, done_cyc); end
        checks++;
        if (wreg_cnt !== 1) begin errors++; $display("FAIL %s_wreg_cycles: got %0d required 1", tag, wreg_cnt); end
        checks++;
        if (pu_arr_is_conv_layer !== 1'b1) begin
            errors++; $display("FAIL %s_is_conv: got %b required 1", tag, pu_arr_is_conv_layer);
        end
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
        checks++;
        if (perf_b !== 101 || perf_s !== 0) begin
            errors++; $display("FAIL %s_perf: got busy=%0d stall=%0d required 101/0", tag, perf_b, perf_s);
        end
`endif
    endtask

    task automatic test_in_stall;
        run_pass(3, 3, 9, 1, 3, 4, -1, 0, -1);
        checks++;
        if (done_cyc !== 105) begin errors++; $display("FAIL in_stall_done_cycle: got %0d required 105", done_cyc); end
        checks++;
        if (stall_dir.size() !== 4) begin
            errors++; $display("FAIL in_stall_len: got %0d required 4", stall_dir.size());
        end
        while (stall_dir.size() > 0) begin
            int d = stall_dir.pop_front();
            int g = stall_ireg.pop_front();
            checks++;
            if (d !== 3 || g !== 0) begin
                errors++; $display("FAIL in_stall_hold: got dir=%0d ireg=%0d required dir=3 ireg=0", d, g);
            end
        end
        checks++;
        if (obs_row.size() !== 9) begin errors++; $display("FAIL in_stall_results: got %0d required 9", obs_row.size()); end
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
        checks++;
        if (perf_b !== 105 || perf_s !== 4) begin
            errors++; $display("FAIL in_stall_perf: got busy=%0d stall=%0d required 105/4", perf_b, perf_s);
        end
`endif
    endtask

    task automatic test_res_stall;
        run_pass(3, 3, 9, 1, -1, 0, 0, 7, -1);
        checks++;
        if (done_cyc !== 108) begin errors++; $display("FAIL res_stall_done_cycle: got %0d required 108", done_cyc); end
        checks++;
        if (stall_row.size() !== 7) begin errors++; $display("FAIL res_stall_len: got %0d required 7", stall_row.size()); end
        while (stall_row.size() > 0) begin
            int r = stall_row.pop_front();
            int c = stall_col.pop_front();
            int p = stall_pu.pop_front();
            checks++;
            if (r !== 0 || c !== 0 || p !== 0) begin
                errors++; $display("FAIL res_stall_hold: got row=%0d col=%0d pu=%0d required 0/0/0", r, c, p);
            end
        end
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
        checks++;
        if (perf_b !== 108 || perf_s !== 7) begin
            errors++; $display("FAIL res_stall_perf: got busy=%0d stall=%0d required 108/7", perf_b, perf_s);
        end
`endif
    endtask

    task automatic test_fc;
        int e, o;
        model_scan(2, 2, 0);
        run_pass(2, 2, 0, 0, -1, 0, -1, 0, -1);
        while (exp_row.size() > 0) begin
            e = exp_dir.pop_front(); o = obs_dir.size() ? obs_dir.pop_front() : -1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL fc_dir: got %0d required %0d", o, e); end
            e = exp_col.pop_front(); o = obs_col.size() ? obs_col.pop_front() : -1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL fc_col: got %0d required %0d", o, e); end
            e = exp_row.pop_front(); o = obs_row.size() ? obs_row.pop_front() : -1;
            checks++;
            if (o !== e) begin errors++; $display("FAIL fc_row: got %0d required %0d", o, e); end
            o = obs_pu.size() ? obs_pu.pop_front() : -1;
            checks++;
            if (o !== 9) begin errors++; $display("FAIL fc_pu_cycles: got %0d required 9", o); end
        end
        checks++;
        if (done_cyc !== 46) begin errors++; $display("FAIL fc_done_cycle: got %0d required 46", done_cyc); end
        checks++;
        if (pu_arr_is_conv_layer !== 1'b0) begin
            errors++; $display("FAIL fc_is_conv: got %b required 0", pu_arr_is_conv_layer);
        end
    endtask

    task automatic test_abort;
        run_pass(3, 3, 9, 1, -1, 0, -1, 0, 2);
        checks++;
        if (ab_busy !== 0) begin errors++; $display("FAIL abort_busy: got %0d required 0", ab_busy); end
        checks++;
        if (ab_en !== 0) begin errors++; $display("FAIL abort_enables: got %0d required 0", ab_en); end
        checks++;
        if (done_cyc !== -1) begin errors++; $display("FAIL abort_no_done: got %0d required -1", done_cyc); end
        checks++;
        if (obs_row.size() !== 2) begin errors++; $display("FAIL abort_results: got %0d required 2", obs_row.size()); end
        test_conv_3x3("rescan");
    endtask

    task automatic test_zero;
        run_pass(0, 3, 9, 1, -1, 0, -1, 0, -1);
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL zero_w_done_cycle: got %0d required 1", done_cyc); end
        checks++;
        if (any_en !== 0) begin errors++; $display("FAIL zero_w_enables: got %0d required 0", any_en); end
`ifdef AL_ACCEL_PU_CTRL_PERF_EN
        checks++;
        if (perf_b !== 1) begin errors++; $display("FAIL zero_w_perf_busy: got %0d required 1", perf_b); end
`endif
        run_pass(2, 0, 3, 1, -1, 0, -1, 0, -1);
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL zero_h_done_cycle: got %0d required 1", done_cyc); end
        checks++;
        if (any_en !== 0 || obs_row.size() !== 0) begin
            errors++; $display("FAIL zero_h_activity: got en=%0d results=%0d required 0/0", any_en, obs_row.size());
        end
    endtask

    initial begin
        test_reset();
        test_conv_3x3("conv3x3");
        test_in_stall();
        test_res_stall();
        test_fc();
        test_abort();
        test_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
